fmult_accum: RTL and testbench



---
 rtl/fmult_accum_pkg.sv | 34 +++
 rtl/fmult_accum_fmult.sv | 59 +++++
 rtl/fmult_accum.sv | 162 ++++++++++++++++
 tb/tb_fmult_accum.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmult_accum_pkg.sv
// Shared definitions for the G.726 predictor estimate: float field layout,
// FMULT scaling constants and the sequencing state enum.
package fmult_accum_pkg;

    localparam int NTERMS = 8;
    localparam int ZTERMS = 6;

    // 11-bit float layout used by dq and sr
    localparam int FLT_SIGN     = 10;
    localparam int FLT_EXP_MSB  = 9;
    localparam int FLT_EXP_LSB  = 6;
    localparam int FLT_MANT_MSB = 5;

    localparam logic [4:0]  WEXP_BIAS   = 5'd26;
    localparam logic [11:0] WMANT_ROUND = 12'd48;
    localparam logic [15:0] AMAG_MASK   = 16'h1FFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    // Position of the highest set bit plus one; zero for a zero operand.
    function automatic logic [3:0] bit_length(input logic [12:0] v);
        logic [3:0] len;
        len = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (v[i]) len = 4'(i + 1);
        end
        return len;
    endfunction

endpackage

// File: rtl/fmult_accum_fmult.sv
// Combinational FMULT: scales a two's complement predictor coefficient by an
// 11-bit float sample and returns a 16-bit two's complement product.
module fmult
    import fmult_accum_pkg::*;
(
    input  logic [15:0] an,
    input  logic [10:0] srn,
    output logic [15:0] wan
);

    logic        an_s;
    logic [15:0] an_shr;
    logic [15:0] an_mag16;
    logic [12:0] an_mag;
    logic [3:0]  an_exp;
    logic [18:0] an_norm;
    logic [5:0]  an_mant;

    logic        sr_s;
    logic [3:0]  sr_exp;
    logic [5:0]  sr_mant;

    logic        wa_s;
    logic [4:0]  wa_exp;
    logic [11:0] mant_sum;
    logic [7:0]  wa_mant;
    logic [3:0]  unused_mant_frac;
    logic [14:0] wa_mant_ext;
    logic [14:0] wa_mag;

    assign an_s     = an[15];
    assign an_shr   = {2'b00, an[15:2]};
    // Negative coefficients are folded to a 13-bit magnitude
    assign an_mag16 = an_s ? ((16'd0 - an_shr) & AMAG_MASK) : an_shr;
    assign an_mag   = an_mag16[12:0];
    assign an_exp   = bit_length(an_mag);
    assign an_norm  = {an_mag, 6'b000000} >> an_exp;
    assign an_mant  = (an_mag == 13'd0) ? 6'd32 : an_norm[5:0];

    assign sr_s    = srn[FLT_SIGN];
    assign sr_exp  = srn[FLT_EXP_MSB:FLT_EXP_LSB];
    assign sr_mant = srn[FLT_MANT_MSB:0];

    assign wa_s     = sr_s ^ an_s;
    assign wa_exp   = {1'b0, sr_exp} + {1'b0, an_exp};
    assign mant_sum = ({6'd0, sr_mant} * {6'd0, an_mant}) + WMANT_ROUND;
    assign {wa_mant, unused_mant_frac} = mant_sum;
    assign wa_mant_ext = {7'd0, wa_mant};

    // Exponents above the bias shift left by at most two, so 15 bits suffice
    assign wa_mag = (wa_exp > WEXP_BIAS) ? (wa_mant_ext << (wa_exp - WEXP_BIAS))
                                         : (wa_mant_ext >> (WEXP_BIAS - wa_exp));

    assign wan = wa_s ? (16'd0 - {1'b0, wa_mag}) : {1'b0, wa_mag};

    logic unused_fmult;
    assign unused_fmult = ^{an[1:0], an_mag16[15:13], an_norm[18:6]};

endmodule

// File: rtl/fmult_accum.sv
// Adaptive predictor estimate: iterates one shared FMULT over the eight
// predictor terms and accumulates them into sez (zero section) and se.
module fmult_accum
    import fmult_accum_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] b1,
    input  logic [15:0] b2,
    input  logic [15:0] b3,
    input  logic [15:0] b4,
    input  logic [15:0] b5,
    input  logic [15:0] b6,
    input  logic [15:0] a1,
    input  logic [15:0] a2,
    input  logic [10:0] dq1,
    input  logic [10:0] dq2,
    input  logic [10:0] dq3,
    input  logic [10:0] dq4,
    input  logic [10:0] dq5,
    input  logic [10:0] dq6,
    input  logic [10:0] sr1,
    input  logic [10:0] sr2,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4,
    output logic [14:0] se,
    output logic [14:0] sez,
    output logic        done
);

    localparam logic [3:0] IDX_SEZ  = 4'(ZTERMS);
    localparam logic [3:0] IDX_LAST = 4'(NTERMS);

    logic [15:0] coef_in  [NTERMS];
    logic [10:0] flt_in   [NTERMS];
    logic [15:0] coef_reg [NTERMS];
    logic [10:0] flt_reg  [NTERMS];

    state_t      state_reg;
    logic [3:0]  idx_reg;
    logic [15:0] wan_reg;
    logic [15:0] acc_reg;
    logic [14:0] sezi_reg;
    logic [14:0] se_reg;
    logic [14:0] sez_reg;
    logic        done_reg;

    logic [15:0] term_coef;
    logic [10:0] term_flt;
    logic [15:0] term_wan;
    logic [15:0] acc_sum;

    // Evaluation order: zero section first, then a2 before a1
    always_comb begin
        coef_in[0] = b1;  flt_in[0] = dq1;
        coef_in[1] = b2;  flt_in[1] = dq2;
        coef_in[2] = b3;  flt_in[2] = dq3;
        coef_in[3] = b4;  flt_in[3] = dq4;
        coef_in[4] = b5;  flt_in[4] = dq5;
        coef_in[5] = b6;  flt_in[5] = dq6;
        coef_in[6] = a2;  flt_in[6] = sr2;
        coef_in[7] = a1;  flt_in[7] = sr1;
    end

    assign term_coef = coef_reg[idx_reg[2:0]];
    assign term_flt  = flt_reg[idx_reg[2:0]];
    assign acc_sum   = acc_reg + wan_reg;

    fmult u_fmult (
        .an  (term_coef),
        .srn (term_flt),
        .wan (term_wan)
    );

    // Products are registered before accumulation, so CALC spans nine edges:
    // index k forms term k and adds term k-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= 4'd0;
            wan_reg   <= 16'd0;
            acc_reg   <= 16'd0;
            sezi_reg  <= 15'd0;
            se_reg    <= 15'd0;
            sez_reg   <= 15'd0;
            done_reg  <= 1'b0;
            for (int i = 0; i < NTERMS; i++) begin
                coef_reg[i] <= 16'd0;
                flt_reg[i]  <= 11'd0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < NTERMS; i++) begin
                            coef_reg[i] <= coef_in[i];
                            flt_reg[i]  <= flt_in[i];
                        end
                        idx_reg   <= 4'd0;
                        wan_reg   <= 16'd0;
                        acc_reg   <= 16'd0;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (idx_reg != IDX_LAST) begin
                        wan_reg <= term_wan;
                    end
                    if (idx_reg != 4'd0) begin
                        acc_reg <= acc_sum;
                    end
                    if (idx_reg == IDX_SEZ) begin
                        sezi_reg <= acc_sum[15:1];
                    end
                    if (idx_reg == IDX_LAST) begin
                        se_reg    <= acc_sum[15:1];
                        sez_reg   <= sezi_reg;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg <= idx_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign se   = se_reg;
    assign sez  = sez_reg;
    assign done = done_reg;

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    logic unused_dft;
    assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                          scan_enable, test_mode};

endmodule

// File: tb/tb_fmult_accum.sv
// Randomized scoreboard bench for fmult_accum: a numeric model of the G.726
// FMULT/ACCUM rules feeds an expectation queue drained on each done pulse.
module tb_fmult_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] b [6];
    logic [15:0] a1, a2;
    logic [10:0] dq [6];
    logic [10:0] sr1, sr2;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
    logic [14:0] se, sez;
    logic        done;

    typedef struct {
        int se;
        int sez;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_count = 0;
    bit   prev_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fmult_accum dut (
        .clk(clk), .reset(reset), .start(start),
        .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]), .b5(b[4]), .b6(b[5]),
        .a1(a1), .a2(a2),
        .dq1(dq[0]), .dq2(dq[1]), .dq3(dq[2]), .dq4(dq[3]), .dq5(dq[4]), .dq6(dq[5]),
        .sr1(sr1), .sr2(sr2),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0),
        .scan_in4(1'b0), .scan_enable(1'b0), .test_mode(1'b0),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4),
        .se(se), .sez(sez), .done(done)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    // Reference FMULT written directly from the arithmetic definition
    function automatic int fmult_ref(input int an, input int srn);
        int ans, mag, aexp, amant, srs, srexp, srmant, ws, wexp, wmant, wmag;
        ans  = (an >> 15) & 1;
        mag  = ans ? ((-(an >> 2)) & 'h1FFF) : (an >> 2);
        aexp = 0;
        while ((mag >> aexp) != 0) aexp++;
        amant  = (mag == 0) ? 32 : ((mag << 6) >> aexp);
        srs    = (srn >> 10) & 1;
        srexp  = (srn >> 6) & 'hF;
        srmant = srn & 'h3F;
        ws     = srs ^ ans;
        wexp   = srexp + aexp;
        wmant  = (srmant * amant + 48) >> 4;
        wmag   = (wexp > 26) ? ((wmant << (wexp - 26)) & 'h7FFF) : (wmant >> (26 - wexp));
        return ws ? ((-wmag) & 'hFFFF) : wmag;
    endfunction

    function automatic exp_t model();
        exp_t e;
        int sezi, sei;
        sezi = 0;
        for (int i = 0; i < 6; i++) sezi = (sezi + fmult_ref(int'(b[i]), int'(dq[i]))) & 'hFFFF;
        sei = (sezi + fmult_ref(int'(a2), int'(sr2)) + fmult_ref(int'(a1), int'(sr1))) & 'hFFFF;
        e.se = sei >> 1;
        e.sez = sezi >> 1;
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 6; i++) begin
            b[i] = 16'd0;
            dq[i] = 11'd0;
        end
        a1 = 16'd0; a2 = 16'd0; sr1 = 11'd0; sr2 = 11'd0;
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 6; i++) begin
            b[i] = 16'($urandom);
            dq[i] = 11'($urandom);
        end
        a1 = 16'($urandom); a2 = 16'($urandom);
        sr1 = 11'($urandom); sr2 = 11'($urandom);
    endtask

    // Issue one computation; hold_start keeps start high until done is seen.
    task automatic do_op(input bit hold_start);
        exp_t e;
        int snap;
        e = model();
        snap = done_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        sb.push_back(e);
        if (!hold_start) begin
            start = 1'b0;
            scramble_inputs();
        end
        for (int i = 0; i < 20 && done_count == snap; i++) begin
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        if (done_count == snap) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done_within_20");
            sb.delete();
        end
        clear_inputs();
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                done_count++;
                if (prev_done) begin
                    checks++;
                    errors++;
                    $display("FAIL done_width actual=2+cycles required=1");
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("se", int'(se), e.se);
                    check("sez", int'(sez), e.sez);
                    check("latency", cyc - e.acc_cyc, 9);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    initial begin
        int snap;
        reset = 1'b1;
        start = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_se", int'(se), 0);
        check("reset_sez", int'(sez), 0);
        check("reset_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        do_op(1'b0);
        b[0] = 16'h4000; dq[0] = 11'h360; do_op(1'b0);
        b[0] = 16'hC000; dq[0] = 11'h360; do_op(1'b0);
        b[0] = 16'h4000; dq[0] = 11'h360; a2 = 16'h4000; sr2 = 11'h360; do_op(1'b0);
        a1 = 16'h4000; sr1 = 11'h760; do_op(1'b0);
        b[0] = 16'h4000; dq[0] = 11'h3E0; do_op(1'b0);

        // Reset in the middle of CALC aborts without a done pulse
        b[0] = 16'h4000; dq[0] = 11'h360;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_se", int'(se), 0);
        check("abort_sez", int'(sez), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        snap = done_count;
        repeat (15) @(negedge clk);
        check("abort_no_done", done_count, snap);

        // start held until done, then dropped: exactly one pulse
        a2 = 16'h4000; sr2 = 11'h360;
        snap = done_count;
        do_op(1'b1);
        repeat (15) @(negedge clk);
        check("held_start_pulses", done_count - snap, 1);

        // Randomized back-to-back operations
        for (int n = 0; n < 24; n++) begin
            scramble_inputs();
            if (n % 4 == 1) begin
                for (int i = 0; i < 6; i += 2) b[i] = 16'd0;
            end
            do_op(n % 5 == 3);
        end

        repeat (15) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
